// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forward-select codes, scoreboard stage indices and parameter defaults.
package hazard_pkg;

    localparam int RA_W_DEF   = 4;
    localparam int PC_REG_DEF = 15;
    localparam int STAT_W_DEF = 16;

    // Scoreboard entry layout is {valid, load, dest}; these name the stage slots.
    localparam int SB_DEPTH = 3;
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry in-flight destination tracker (EX, MEM, WB). A stall inserts
// a bubble into EX while MEM and WB keep advancing.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
)
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           stall_i,
    input  logic                           wr_en_i,
    input  logic                           load_i,
    input  logic [RA_W-1:0]                dest_i,
    output logic [SB_DEPTH-1:0]            valid_o,
    output logic [SB_DEPTH-1:0]            load_o,
    output logic [SB_DEPTH-1:0][RA_W-1:0]  dest_o
);

    logic [SB_DEPTH-1:0]           valid_q, valid_d;
    logic [SB_DEPTH-1:0]           load_q,  load_d;
    logic [SB_DEPTH-1:0][RA_W-1:0] dest_q,  dest_d;

    always_comb begin
        valid_d         = valid_q;
        load_d          = load_q;
        dest_d          = dest_q;
        valid_d[SB_WB]  = valid_q[SB_MEM];
        load_d[SB_WB]   = load_q[SB_MEM];
        dest_d[SB_WB]   = dest_q[SB_MEM];
        valid_d[SB_MEM] = valid_q[SB_EX];
        load_d[SB_MEM]  = load_q[SB_EX];
        dest_d[SB_MEM]  = dest_q[SB_EX];
        // A stalled ID instruction is re-presented next cycle, so EX gets a bubble.
        valid_d[SB_EX]  = wr_en_i & ~stall_i;
        load_d[SB_EX]   = load_i & ~stall_i;
        dest_d[SB_EX]   = dest_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            load_q  <= '0;
            dest_q  <= '0;
        end else begin
            valid_q <= valid_d;
            load_q  <= load_d;
            dest_q  <= dest_d;
        end
    end

    assign valid_o = valid_q;
    assign load_o  = load_q;
    assign dest_o  = dest_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard controller: operand forwarding selects, load-use stall and branch flush.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int RA_W   = RA_W_DEF,
    parameter int PC_REG = PC_REG_DEF,
    parameter int STAT_W = STAT_W_DEF
)
(
    input  logic              CLK,
    input  logic              CLR,
    input  logic [RA_W-1:0]   ID_Rn,
    input  logic [RA_W-1:0]   ID_Rm,
    input  logic [RA_W-1:0]   ID_Rd_src,
    input  logic              ID_use_Rn,
    input  logic              ID_use_Rm,
    input  logic              ID_use_Rd,
    input  logic [RA_W-1:0]   ID_dest,
    input  logic              ID_RF_enable,
    input  logic              ID_Load_Inst,
    input  logic              ID_B_taken,
    output logic              PC_LE,
    output logic              IFID_LE,
    output logic              CU_mux_sel,
    output logic              IFID_CLR,
    output logic [1:0]        fwd_A,
    output logic [1:0]        fwd_B,
    output logic [1:0]        fwd_C,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_REG);

    logic [SB_DEPTH-1:0]           sb_valid;
    logic [SB_DEPTH-1:0]           sb_load;
    logic [SB_DEPTH-1:0][RA_W-1:0] sb_dest;

    logic [SB_DEPTH-1:0] hit_a, hit_b, hit_c;
    fwd_sel_e            sel_a, sel_b, sel_c;
    logic                load_use;
    logic                stall;
    logic                flush;

    function automatic logic entry_hit(input logic v, input logic [RA_W-1:0] d,
                                       input logic [RA_W-1:0] s, input logic u);
        return v & u & (d == s) & (s != PC_ADDR);
    endfunction

    function automatic fwd_sel_e pick(input logic [SB_DEPTH-1:0] hit);
        if (hit[SB_EX])       return FWD_EX;
        else if (hit[SB_MEM]) return FWD_MEM;
        else if (hit[SB_WB])  return FWD_WB;
        else                  return FWD_RF;
    endfunction

    hazard_scoreboard #(.RA_W(RA_W)) u_scoreboard (
        .clk_i   (CLK),
        .rst_i   (CLR),
        .stall_i (stall),
        .wr_en_i (ID_RF_enable),
        .load_i  (ID_Load_Inst),
        .dest_i  (ID_dest),
        .valid_o (sb_valid),
        .load_o  (sb_load),
        .dest_o  (sb_dest)
    );

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        hit_c = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            hit_a[i] = entry_hit(sb_valid[i], sb_dest[i], ID_Rn,     ID_use_Rn);
            hit_b[i] = entry_hit(sb_valid[i], sb_dest[i], ID_Rm,     ID_use_Rm);
            hit_c[i] = entry_hit(sb_valid[i], sb_dest[i], ID_Rd_src, ID_use_Rd);
        end
        sel_a = pick(hit_a);
        sel_b = pick(hit_b);
        sel_c = pick(hit_c);
    end

    // Load data is only available after MEM, so a load in EX feeding ID must wait one cycle.
    assign load_use = sb_load[SB_EX] & (hit_a[SB_EX] | hit_b[SB_EX] | hit_c[SB_EX]);
    assign stall    = load_use & ~CLR;
    assign flush    = ID_B_taken & ~stall & ~CLR;

    assign PC_LE      = ~stall;
    assign IFID_LE    = ~stall;
    assign CU_mux_sel = stall;
    assign IFID_CLR   = flush;
    assign fwd_A      = CLR ? FWD_RF : sel_a;
    assign fwd_B      = CLR ? FWD_RF : sel_b;
    assign fwd_C      = CLR ? FWD_RF : sel_c;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and randomized bench for hazard_forward_unit against an
// age-ordered history model of the last three issued instructions.
module tb_hazard_forward_unit;

    localparam int RA_W   = 4;
    localparam int PC_REG = 15;
    localparam int STAT_W = 16;
    localparam int SAT    = (1 << STAT_W) - 1;

    logic              CLK = 1'b0;
    logic              CLR;
    logic [RA_W-1:0]   ID_Rn, ID_Rm, ID_Rd_src, ID_dest;
    logic              ID_use_Rn, ID_use_Rm, ID_use_Rd;
    logic              ID_RF_enable, ID_Load_Inst, ID_B_taken;
    logic              PC_LE, IFID_LE, CU_mux_sel, IFID_CLR;
    logic [1:0]        fwd_A, fwd_B, fwd_C;
    logic [STAT_W-1:0] stall_cnt, flush_cnt;

    hazard_forward_unit #(.RA_W(RA_W), .PC_REG(PC_REG), .STAT_W(STAT_W)) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .ID_Rn        (ID_Rn),
        .ID_Rm        (ID_Rm),
        .ID_Rd_src    (ID_Rd_src),
        .ID_use_Rn    (ID_use_Rn),
        .ID_use_Rm    (ID_use_Rm),
        .ID_use_Rd    (ID_use_Rd),
        .ID_dest      (ID_dest),
        .ID_RF_enable (ID_RF_enable),
        .ID_Load_Inst (ID_Load_Inst),
        .ID_B_taken   (ID_B_taken),
        .PC_LE        (PC_LE),
        .IFID_LE      (IFID_LE),
        .CU_mux_sel   (CU_mux_sel),
        .IFID_CLR     (IFID_CLR),
        .fwd_A        (fwd_A),
        .fwd_B        (fwd_B),
        .fwd_C        (fwd_C),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // History of issued instructions: age 0 = most recent (in EX), 2 = oldest (in WB).
    typedef struct { bit wr; bit ld; int dest; } inst_t;
    inst_t hist[3];
    int    m_stalls, m_flushes;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '{wr: 0, ld: 0, dest: 0};
        m_stalls  = 0;
        m_flushes = 0;
    endfunction

    function automatic int exp_fwd(input bit use_src, input int src);
        if (!use_src || src == PC_REG) return 0;
        for (int age = 0; age < 3; age++)
            if (hist[age].wr && hist[age].dest == src) return age + 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        if (!(hist[0].wr && hist[0].ld)) return 0;
        return (ID_use_Rn && int'(ID_Rn)     != PC_REG && int'(ID_Rn)     == hist[0].dest) ||
               (ID_use_Rm && int'(ID_Rm)     != PC_REG && int'(ID_Rm)     == hist[0].dest) ||
               (ID_use_Rd && int'(ID_Rd_src) != PC_REG && int'(ID_Rd_src) == hist[0].dest);
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef HAZARD_STATS_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic drive(input int rn, input int rm, input int rd, input bit urn, input bit urm,
                         input bit urd, input int dest, input bit wr, input bit ld, input bit bt);
        ID_Rn        = RA_W'(rn);
        ID_Rm        = RA_W'(rm);
        ID_Rd_src    = RA_W'(rd);
        ID_use_Rn    = urn;
        ID_use_Rm    = urm;
        ID_use_Rd    = urd;
        ID_dest      = RA_W'(dest);
        ID_RF_enable = wr;
        ID_Load_Inst = ld;
        ID_B_taken   = bt;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Check all outputs on the falling edge, then retire the cycle into the model.
    task automatic cycle(input string tag);
        bit st, fl;
        @(negedge CLK);
        st = exp_stall();
        fl = ID_B_taken && !st;
        check_val({tag, ".PC_LE"},    int'(PC_LE),      int'(!st));
        check_val({tag, ".IFID_LE"},  int'(IFID_LE),    int'(!st));
        check_val({tag, ".CU_mux"},   int'(CU_mux_sel), int'(st));
        check_val({tag, ".IFID_CLR"}, int'(IFID_CLR),   int'(fl));
        check_val({tag, ".fwd_A"},    int'(fwd_A),      exp_fwd(ID_use_Rn, int'(ID_Rn)));
        check_val({tag, ".fwd_B"},    int'(fwd_B),      exp_fwd(ID_use_Rm, int'(ID_Rm)));
        check_val({tag, ".fwd_C"},    int'(fwd_C),      exp_fwd(ID_use_Rd, int'(ID_Rd_src)));
        check_val({tag, ".stall_cnt"}, int'(stall_cnt), exp_cnt(m_stalls));
        check_val({tag, ".flush_cnt"}, int'(flush_cnt), exp_cnt(m_flushes));
        @(posedge CLK);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{wr: ID_RF_enable && !st, ld: ID_Load_Inst && !st, dest: int'(ID_dest)};
        if (st && m_stalls < SAT)  m_stalls++;
        if (fl && m_flushes < SAT) m_flushes++;
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) cycle("drain");
    endtask

    initial begin
        model_reset();
        CLR = 1'b1;
        drive(5, 5, 5, 1, 1, 1, 5, 1, 1, 1);
        #2;
        check_val("rst.PC_LE",    int'(PC_LE),      1);
        check_val("rst.IFID_LE",  int'(IFID_LE),    1);
        check_val("rst.CU_mux",   int'(CU_mux_sel), 0);
        check_val("rst.IFID_CLR", int'(IFID_CLR),   0);
        check_val("rst.fwd_A",    int'(fwd_A),      0);
        check_val("rst.stall_cnt", int'(stall_cnt), 0);
        nop();
        @(negedge CLK);
        CLR = 1'b0;
        @(posedge CLK);
        #1;

        // ADD R5 then SUB R3,R5: EX forward on Rm, no stall
        drive(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);  cycle("t1.add");
        drive(3, 5, 0, 1, 1, 0, 3, 1, 0, 0);  cycle("t1.sub");
        check_val("t1.fwd_B_ex", int'(hist[1].dest), 5);
        drain();

        // LDR R2 then ADD R4,R2,R1: one stall cycle, then MEM forward
        drive(0, 0, 0, 0, 0, 0, 2, 1, 1, 0);  cycle("t2.ldr");
        drive(2, 1, 0, 1, 1, 0, 4, 1, 0, 0);
        @(negedge CLK);
        check_val("t2.stall_pc", int'(PC_LE), 0);
        check_val("t2.stall_cu", int'(CU_mux_sel), 1);
        @(posedge CLK); #1;
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = '{wr: 0, ld: 0, dest: 4};
        m_stalls++;
        @(negedge CLK);
        check_val("t2.fwd_A_mem", int'(fwd_A), 2);
        check_val("t2.no_stall",  int'(PC_LE), 1);
        check_val("t2.stall_cnt", int'(stall_cnt), exp_cnt(1));
        @(posedge CLK); #1;
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = '{wr: 1, ld: 0, dest: 4};
        drain();

        // R7 in EX, MEM and WB simultaneously: EX wins
        repeat (3) begin
            drive(0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
            cycle("t3.wr7");
        end
        drive(7, 0, 7, 1, 0, 1, 1, 0, 0, 0);  cycle("t3.rd7");
        drain();

        // R15 is never forwarded; unused source never forwarded
        drive(0, 0, 0, 0, 0, 0, 15, 1, 1, 0); cycle("t4.wr15");
        drive(15, 15, 15, 1, 1, 1, 0, 0, 0, 0); cycle("t4.rd15");
        drive(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);  cycle("t4.wr5");
        drive(5, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cycle("t4.nouse");
        drain();

        // Taken branch with no hazard, then the same branch behind a load-use
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);  cycle("t5.br");
        drive(0, 0, 0, 0, 0, 0, 9, 1, 1, 0);  cycle("t5.ld9");
        drive(9, 0, 0, 1, 0, 0, 0, 0, 0, 1);  cycle("t5.br_stall");
        cycle("t5.br_flush");
        drain();

        // Reset asserted mid-stall cancels it at once and empties the scoreboard
        drive(0, 0, 0, 0, 0, 0, 6, 1, 1, 0);  cycle("t6.ld6");
        drive(6, 0, 0, 1, 0, 0, 3, 1, 0, 1);
        #2;
        check_val("t6.pre_stall", int'(CU_mux_sel), 1);
        CLR = 1'b1;
        #1;
        check_val("t6.rst_pc",   int'(PC_LE),      1);
        check_val("t6.rst_cu",   int'(CU_mux_sel), 0);
        check_val("t6.rst_flush", int'(IFID_CLR),  0);
        check_val("t6.rst_fwd",  int'(fwd_A),      0);
        model_reset();
        CLR = 1'b0;
        drive(6, 6, 6, 1, 1, 1, 0, 0, 0, 0);  cycle("t6.post");
        drain();

        // Randomized traffic over a small register set to provoke frequent hazards
        for (int n = 0; n < 400; n++) begin
            int pick[4];
            for (int k = 0; k < 4; k++)
                pick[k] = ($urandom_range(0, 9) == 0) ? PC_REG : int'($urandom_range(0, 5));
            drive(pick[0], pick[1], pick[2],
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 3) == 0), pick[3],
                  bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 4) == 0));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
